// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_t       : responder FSM states (IDLE, WAIT, RESP)
//   op_t          : latched request kind (OP_RD, OP_WR, OP_ILL)
//   DMEM_WAIT_MAX : largest supported wait-state count
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_ILL} op_t;
    localparam int DMEM_WAIT_MAX = 15;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x DATA_W storage, one synchronous write port and one read port, no reset.
//   clock : write clock
//   we    : write enable, sampled on the rising edge
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data for raddr (combinational)
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256
)(
    input  logic                           clock,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [DATA_W-1:0]              wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [DATA_W-1:0]              rdata
);
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder with ready/request handshake and programmable wait states.
//   clock, reset     : clock and asynchronous active-high reset
//   mem_rd, mem_wr   : read / write request (both high = illegal request)
//   addr, wdata      : byte address and write data, latched at accept
//   req_ready        : responder idle, request accepted when high together with mem_rd or mem_wr
//   rdata, rvalid    : registered read data and its one-cycle valid pulse
//   wr_done          : one-cycle write-completion pulse
//   err              : one-cycle error pulse, replaces rvalid / wr_done
//   busy             : request outstanding
// Optional feature: define DMEM_MISALIGN_ERR_EN to answer addr[1:0]!=0 requests with err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              req_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              wr_done,
    output logic              err,
    output logic              busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int WC = (WAIT_CYCLES > DMEM_WAIT_MAX) ? DMEM_WAIT_MAX : WAIT_CYCLES;
    localparam logic [3:0] WAIT_LOAD = (WC > 0) ? 4'(WC - 1) : 4'd0;

    state_t            state_q, state_d;
    op_t               op_q, op_d, req_op, cur_op;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d, cur_idx;
    logic [DATA_W-1:0] wdata_q, wdata_d, cur_wdata, arr_rdata;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rvalid_q, rvalid_d, wr_done_q, wr_done_d, err_q, err_d;
    logic              accept, enter, arr_we;
    logic              unused_addr;

    // Word index uses only addr[AW+1:2]; the rest wraps or is ignored.
    assign unused_addr = ^{addr[DATA_W-1:AW+2], addr[1:0]};

    always_comb begin
        req_op = (mem_rd && mem_wr) ? OP_ILL : (mem_wr ? OP_WR : OP_RD);
`ifdef DMEM_MISALIGN_ERR_EN
        if (addr[1:0] != 2'b00) req_op = OP_ILL;
`endif
    end

    assign accept = (state_q == IDLE) && req_ready_q && (mem_rd || mem_wr);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        enter       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = !accept;
                if (accept) begin
                    op_d    = req_op;
                    idx_d   = addr[AW+1:2];
                    wdata_d = wdata;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WC == 0) ? RESP : WAIT;
                    enter   = (WC == 0);
                end
            end
            WAIT: begin
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                state_d = (cnt_q == 4'd0) ? RESP : WAIT;
                enter   = (cnt_q == 4'd0);
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states RESP is entered on the accept edge itself, so the
    // array is driven straight from the request rather than the latched copy.
    assign cur_op    = (state_q == IDLE) ? req_op : op_q;
    assign cur_idx   = (state_q == IDLE) ? addr[AW+1:2] : idx_q;
    assign cur_wdata = (state_q == IDLE) ? wdata : wdata_q;
    assign arr_we    = enter && (cur_op == OP_WR);

    assign rvalid_d  = enter && (cur_op == OP_RD);
    assign wr_done_d = enter && (cur_op == OP_WR);
    assign err_d     = enter && (cur_op == OP_ILL);
    assign rdata_d   = rvalid_d ? arr_rdata : '0;

    dmem_array #(.DATA_W(DATA_W), .DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clock (clock),
        .we    (arr_we),
        .waddr (cur_idx),
        .wdata (cur_wdata),
        .raddr (cur_idx),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_q        <= OP_RD;
            idx_q       <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            wr_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            wr_done_q   <= wr_done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign wr_done   = wr_done_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 for back-to-back).
module tb_dmem_responder;
    localparam int WM = 2;

    logic        clock, reset;
    logic        mem_rd, mem_wr, req_ready, rvalid, wr_done, err, busy;
    logic [31:0] addr, wdata, rdata;
    logic        mem_rd0, mem_wr0, req_ready0, rvalid0, wr_done0, err0, busy0;
    logic [31:0] addr0, wdata0, rdata0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [256];

    dmem_responder #(.DATA_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(WM)) u_dut (
        .clock(clock), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr), .wdata(wdata),
        .req_ready(req_ready), .rdata(rdata), .rvalid(rvalid), .wr_done(wr_done), .err(err), .busy(busy)
    );

    dmem_responder #(.DATA_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
        .clock(clock), .reset(reset), .mem_rd(mem_rd0), .mem_wr(mem_wr0), .addr(addr0), .wdata(wdata0),
        .req_ready(req_ready0), .rdata(rdata0), .rvalid(rvalid0), .wr_done(wr_done0), .err(err0), .busy(busy0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: word-addressed memory, response kind as {err, wr_done, rvalid}.
    function automatic void model(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                                  output logic [2:0] k, output logic [31:0] r);
        int w;
        bit bad;
        w   = int'((a / 4) % 256);
        bad = rd && wr;
`ifdef DMEM_MISALIGN_ERR_EN
        bad = bad || (a % 4 != 0);
`endif
        r = 32'h0;
        if (bad) k = 3'b100;
        else if (wr) begin
            k = 3'b010;
            mdl[w] = d;
        end else begin
            k = 3'b001;
            r = mdl[w];
        end
    endfunction

    // Issues one request on the main instance and observes the response:
    // lat = cycles after accept edge until the pulse is seen (-1 if never),
    // rdy/extra = req_ready and any pulse in the cycle after the response.
    task automatic xact(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [2:0] k, output logic [31:0] r,
                        output logic rdy, output logic extra);
        int n;
        n = 0; lat = -1; k = '0; r = '0; rdy = 1'b0; extra = 1'b0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (req_ready !== 1'b1) return;
        mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
        @(posedge clock);
        #1;
        mem_rd = 1'b0; mem_wr = 1'b0; addr = $urandom; wdata = $urandom;
        for (int i = 1; i <= WM + 4 && lat < 0; i++) begin
            @(negedge clock);
            if (rvalid || wr_done || err) begin
                lat = i; k = {err, wr_done, rvalid}; r = rdata;
            end
        end
        @(negedge clock);
        rdy = req_ready;
        extra = rvalid | wr_done | err;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        checks++;
        if ({req_ready, rvalid, wr_done, err, busy, rdata, req_ready0, busy0, rvalid0} !== '0)
            $display("FAIL reset_values: ready=%b rvalid=%b wr_done=%b err=%b busy=%b rdata=%h, required all 0",
                     req_ready, rvalid, wr_done, err, busy, rdata);
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready_low: ready=%b, required 0 before first edge", req_ready);
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || req_ready0 !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_ready_high: ready=%b ready0=%b busy=%b, required 1 1 0", req_ready, req_ready0, busy);
        errors += 0;
    endtask

    task automatic test_write_read;
        int lat; logic [2:0] k, ek; logic [31:0] r, er; logic rdy, ex;
        xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, k, r, rdy, ex);
        model(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ek, er);
        checks++;
        if (lat !== WM + 1 || k !== 3'b010 || rdy !== 1'b1 || ex !== 1'b0) begin
            errors++;
            $display("FAIL write_0x10: lat=%0d kind=%b ready=%b extra=%b, required lat=%0d kind=010 ready=1 extra=0",
                     lat, k, rdy, ex, WM + 1);
        end
        xact(1'b1, 1'b0, 32'h10, 32'h0, lat, k, r, rdy, ex);
        model(1'b1, 1'b0, 32'h10, 32'h0, ek, er);
        checks++;
        if (lat !== WM + 1 || k !== 3'b001 || r !== 32'hDEADBEEF || rdy !== 1'b1 || ex !== 1'b0) begin
            errors++;
            $display("FAIL read_0x10: lat=%0d kind=%b rdata=%h ready=%b, required lat=%0d kind=001 rdata=deadbeef ready=1",
                     lat, k, r, rdy, WM + 1);
        end
    endtask

    task automatic test_illegal;
        int lat; logic [2:0] k, ek; logic [31:0] r, er; logic rdy, ex;
        xact(1'b0, 1'b1, 32'h20, 32'h11111111, lat, k, r, rdy, ex);
        model(1'b0, 1'b1, 32'h20, 32'h11111111, ek, er);
        checks++;
        if (k !== 3'b010) begin
            errors++;
            $display("FAIL illegal_prewrite: kind=%b, required 010", k);
        end
        xact(1'b1, 1'b1, 32'h20, 32'h5, lat, k, r, rdy, ex);
        model(1'b1, 1'b1, 32'h20, 32'h5, ek, er);
        checks++;
        if (lat !== WM + 1 || k !== 3'b100 || r !== 32'h0 || ex !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL illegal_err: lat=%0d kind=%b rdata=%h extra=%b ready=%b, required lat=%0d kind=100 rdata=0 extra=0 ready=1",
                     lat, k, r, ex, rdy, WM + 1);
        end
        xact(1'b1, 1'b0, 32'h20, 32'h0, lat, k, r, rdy, ex);
        model(1'b1, 1'b0, 32'h20, 32'h0, ek, er);
        checks++;
        if (k !== 3'b001 || r !== 32'h11111111) begin
            errors++;
            $display("FAIL illegal_no_write: kind=%b rdata=%h, required kind=001 rdata=11111111", k, r);
        end
    endtask

    task automatic test_misaligned;
        int lat; logic [2:0] k, ek; logic [31:0] r, er; logic rdy, ex;
        xact(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, lat, k, r, rdy, ex);
        model(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, ek, er);
        xact(1'b1, 1'b0, 32'h13, 32'h0, lat, k, r, rdy, ex);
        model(1'b1, 1'b0, 32'h13, 32'h0, ek, er);
        checks++;
        if (lat !== WM + 1 || k !== ek || r !== er) begin
            errors++;
            $display("FAIL misaligned_read: lat=%0d kind=%b rdata=%h, required lat=%0d kind=%b rdata=%h",
                     lat, k, r, WM + 1, ek, er);
        end
    endtask

    task automatic test_wrap;
        int lat; logic [2:0] k, ek; logic [31:0] r, er; logic rdy, ex;
        xact(1'b0, 1'b1, 32'h400, 32'h1234, lat, k, r, rdy, ex);
        model(1'b0, 1'b1, 32'h400, 32'h1234, ek, er);
        xact(1'b1, 1'b0, 32'h000, 32'h0, lat, k, r, rdy, ex);
        model(1'b1, 1'b0, 32'h000, 32'h0, ek, er);
        checks++;
        if (k !== 3'b001 || r !== 32'h1234) begin
            errors++;
            $display("FAIL wrap_read_0x000: kind=%b rdata=%h, required kind=001 rdata=00001234", k, r);
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [2:0] k, ek; logic [31:0] r, er; logic rdy, ex, seen;
        xact(1'b0, 1'b1, 32'h20, 32'h1, lat, k, r, rdy, ex);
        model(1'b0, 1'b1, 32'h20, 32'h1, ek, er);
        mem_wr = 1'b1; addr = 32'h20; wdata = 32'h2;
        @(posedge clock);
        #1;
        mem_wr = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_busy: busy=%b ready=%b, required 1 0", busy, req_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, rvalid, wr_done, err, busy, rdata} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: ready=%b rvalid=%b wr_done=%b err=%b busy=%b rdata=%h, required all 0",
                     req_ready, rvalid, wr_done, err, busy, rdata);
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clock);
            seen |= wr_done;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            seen |= wr_done;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_wr_done: wr_done seen=%b, required 0", seen);
        end
        xact(1'b1, 1'b0, 32'h20, 32'h0, lat, k, r, rdy, ex);
        model(1'b1, 1'b0, 32'h20, 32'h0, ek, er);
        checks++;
        if (k !== 3'b001 || r !== 32'h1) begin
            errors++;
            $display("FAIL midreset_old_value: kind=%b rdata=%h, required kind=001 rdata=00000001", k, r);
        end
    endtask

    task automatic test_random;
        int lat; logic [2:0] k, ek; logic [31:0] r, er, a, d; logic rdy, ex, rd, wr;
        int sel;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            a = 32'((64 + i) * 4);
            xact(1'b0, 1'b1, a, d, lat, k, r, rdy, ex);
            model(1'b0, 1'b1, a, d, ek, er);
            checks++;
            if (lat !== WM + 1 || k !== ek) begin
                errors++;
                $display("FAIL rand_fill[%0d]: lat=%0d kind=%b, required lat=%0d kind=%b", i, lat, k, WM + 1, ek);
            end
        end
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel < 2) || (sel > 4);
            wr  = (sel < 5);
            a   = (32'($urandom_range(0, 63)) << 10) | (32'(64 + $urandom_range(0, 15)) << 2)
                | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            d   = $urandom;
            xact(rd, wr, a, d, lat, k, r, rdy, ex);
            model(rd, wr, a, d, ek, er);
            checks++;
            if (lat !== WM + 1 || k !== ek || r !== er || rdy !== 1'b1 || ex !== 1'b0) begin
                errors++;
                $display("FAIL rand[%0d] rd=%b wr=%b a=%h: lat=%0d kind=%b rdata=%h ready=%b extra=%b, required lat=%0d kind=%b rdata=%h ready=1 extra=0",
                         i, rd, wr, a, lat, k, r, rdy, ex, WM + 1, ek, er);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [31:0] d0;
        n = 0;
        while (req_ready0 !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        d0 = $urandom;
        mem_wr0 = 1'b1; addr0 = 32'h40; wdata0 = d0;
        @(posedge clock);
        #1;
        mem_wr0 = 1'b0;
        @(negedge clock);
        checks++;
        if ({err0, wr_done0, rvalid0} !== 3'b010) begin
            errors++;
            $display("FAIL b2b_write_w0: kind=%b, required 010 in cycle after accept", {err0, wr_done0, rvalid0});
        end
        @(negedge clock);
        mem_rd0 = 1'b1; addr0 = 32'h40;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (req_ready0 !== (i % 2 == 0) || rvalid0 !== (i % 2 == 1) || (rvalid0 && rdata0 !== d0)) begin
                errors++;
                $display("FAIL b2b_cycle[%0d]: ready=%b rvalid=%b rdata=%h, required ready=%b rvalid=%b rdata=%h",
                         i, req_ready0, rvalid0, rdata0, i % 2 == 0, i % 2 == 1, d0);
            end
            @(negedge clock);
        end
        mem_rd0 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0;
        mem_rd0 = 1'b0; mem_wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        test_reset;
        test_write_read;
        test_illegal;
        test_misaligned;
        test_wrap;
        test_reset_mid;
        test_random;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the load/store port of the processor's memory stage. It accepts one read or write request at a time through a ready/request handshake and latches address and write data. After a programmable number of wait states it commits the write or returns registered read data. It is the memory-side end of the datapath's MR/MW/RA/WD/RD interface and replaces the zero-latency data memory, so the pipeline can be exercised against realistic stalls.

## Interface
Parameters:
- DATA_W, 32, data and address width
- DEPTH_WORDS, 256, number of 32-bit words; power of two
- WAIT_CYCLES, 2, wait states between accept and response; range 0..15

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all control state
- mem_rd  input  1  read request
- mem_wr  input  1  write request
- addr  input  DATA_W  byte address
- wdata  input  DATA_W  write data
- req_ready  output  1  responder idle; a request is accepted on an edge where req_ready and (mem_rd or mem_wr) are both high
- rdata  output  DATA_W  registered read data; valid only while rvalid is high
- rvalid  output  1  one-cycle read-response pulse
- wr_done  output  1  one-cycle write-completion pulse
- err  output  1  one-cycle error-response pulse, replaces rvalid/wr_done
- busy  output  1  request outstanding (state is not IDLE)

## Operation
- FSM states:
  - IDLE: accepts a request. Moves to WAIT if WAIT_CYCLES>0, otherwise to RESP.
  - WAIT: 4-bit down-counter loaded with WAIT_CYCLES-1 at accept. Moves to RESP when the counter reaches 0.
  - RESP: lasts exactly one cycle, then returns to IDLE.
- Request fields (op, addr, wdata) are latched at accept. The requester need not hold them after the accept edge.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Write: the array is updated on the edge entering RESP, and wr_done is high during RESP.
- Read: rdata is loaded from the array on the edge entering RESP, and rvalid is high during RESP.
- mem_rd and mem_wr both high at accept: the request is accepted as illegal and follows normal latency. In RESP, err is high, there is no array access, and rdata is 0.
- Requests presented while req_ready is low are ignored. No queueing.

## Timing
- Reset values: req_ready=0, rdata=0, rvalid=0, wr_done=0, err=0, busy=0, state=IDLE, counter=0.
- req_ready is a register. It goes to 1 on the first edge after reset deasserts, drops on the accept edge, and returns to 1 on the edge leaving RESP.
- Latency: for a request accepted at edge E0, the response pulse occupies the cycle following edge E0+WAIT_CYCLES. For WAIT_CYCLES=0, that is the cycle right after E0.
- Throughput: one request per WAIT_CYCLES+2 cycles.
- A read accepted after a write's RESP cycle observes that write.
- Reset asserted mid-operation: the FSM immediately returns to IDLE, the outstanding request is dropped, and a pending write is not committed. Array contents are never affected by reset.
- rvalid, wr_done and err are mutually exclusive.

## Configuration
- DMEM_MISALIGN_ERR_EN defined: a request with addr[1:0]!=0 follows normal latency. In RESP, err=1, rdata=0, and no write is performed.
- Not defined: addr[1:0] is ignored and the request is serviced as word-aligned.
- The illegal rd+wr case produces err in both builds.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP)
  - the op encoding (OP_RD, OP_WR, OP_ILL)
  - the constant DMEM_WAIT_MAX=15
- Sub-module dmem_array: DEPTH_WORDS×DATA_W storage with one synchronous write port and one read port. It has no reset. The FSM, counter and output registers stay in dmem_responder.

## Test plan
- Write then read: with WAIT_CYCLES=2, write 0xDEADBEEF to 0x10 accepted at E0. Required: wr_done high in the cycle after E0+2 and req_ready back high one edge later. A subsequent read of 0x10 returns rvalid with rdata=0xDEADBEEF.
- Back-to-back: with WAIT_CYCLES=0, hold mem_rd high. Required: req_ready toggles 1,0,1,0 and rvalid pulses every 2 cycles.
- Illegal request: mem_rd=mem_wr=1, addr=0x20, wdata=0x5. Required: err pulses for one cycle, with no rvalid or wr_done. A later read of 0x20 returns its prior value.
- Reset mid-request: 0x1 is already written at 0x20. Write 0x2 to 0x20 and assert reset during WAIT. Required: all outputs are 0 immediately and no wr_done occurs. After reset, a read of 0x20 returns 0x1.
- Misaligned access: read 0x13 after writing 0xA5A5A5A5 to 0x10. With DMEM_MISALIGN_ERR_EN: err=1 and rdata=0. Without it: rvalid=1 and rdata=0xA5A5A5A5.
- Address wrap: with DEPTH_WORDS=256, write 0x1234 to 0x400. Required: a read of 0x000 returns 0x1234.
